lut_table_scanner: RTL and testbench

Sweeps every input code of an attached combinational LUT neuron and streams the resulting truth table out as packed words on a valid/ready interface. The block drives the neuron's input bus, captures the neuron's output, and packs the results for host-side readback. It sits beside a generated neuron instance in the synthesis-check and verification flow. It is the reader counterpart to the truth-table writer that generates the neuron.

---
 rtl/lut_table_scanner.sv | 149 ++++++++++++++
 tb/tb_lut_table_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_table_scanner.sv
// Sweeps every input code of a combinational LUT neuron and streams the packed truth table out.
// Optional trailing checksum word is enabled by defining LUT_SCAN_CHECKSUM_EN.
module lut_table_scanner #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1,
   parameter int WORD_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   output logic [IN_BITS-1:0]  lut_addr,
   input  logic [OUT_BITS-1:0] lut_data,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                busy,
   output logic                done,
   output logic [2:0]          dbg_state_o
);

   localparam int EPW   = WORD_W / OUT_BITS;
   localparam int IDX_W = (EPW > 1) ? $clog2(EPW) : 1;
   localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SAMPLE = 3'd2,
      S_EMIT   = 3'd3,
`ifdef LUT_SCAN_CHECKSUM_EN
      S_CHECK  = 3'd4,
`endif
      S_FINISH = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [IN_BITS-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic               hs;

`ifdef LUT_SCAN_CHECKSUM_EN
   logic [WORD_W-1:0]  sum_q, sum_d;
`endif

   // Valid/ready: a word transfers on any edge where m_valid && m_ready; m_data/m_last hold until then.
`ifdef LUT_SCAN_CHECKSUM_EN
   assign m_valid = (state_q == S_EMIT) || (state_q == S_CHECK);
   assign m_last  = (state_q == S_CHECK);
`else
   assign m_valid = (state_q == S_EMIT);
   assign m_last  = (state_q == S_EMIT) && (addr_q == LAST_ADDR);
`endif
   assign hs          = m_valid && m_ready;
   assign m_data      = pack_q;
   assign lut_addr    = addr_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FINISH);
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      pack_d  = pack_q;
`ifdef LUT_SCAN_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = '0;
               idx_d   = '0;
               pack_d  = '0;
`ifdef LUT_SCAN_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: state_d = S_SAMPLE;
         S_SAMPLE: begin
            pack_d[idx_q*OUT_BITS +: OUT_BITS] = lut_data;
            if ((idx_q == IDX_W'(EPW - 1)) || (addr_q == LAST_ADDR)) begin
               idx_d   = '0;
               state_d = S_EMIT;
            end else begin
               idx_d   = idx_q + 1'b1;
               addr_d  = addr_q + 1'b1;
               state_d = S_DRIVE;
            end
         end
         S_EMIT: begin
            if (hs) begin
`ifdef LUT_SCAN_CHECKSUM_EN
               sum_d = sum_q + pack_q;
`endif
               if (addr_q != LAST_ADDR) begin
                  pack_d  = '0;
                  addr_d  = addr_q + 1'b1;
                  state_d = S_DRIVE;
               end else begin
`ifdef LUT_SCAN_CHECKSUM_EN
                  // The pack register doubles as the output holder for the checksum word.
                  pack_d  = sum_q + pack_q;
                  state_d = S_CHECK;
`else
                  state_d = S_FINISH;
`endif
               end
            end
         end
`ifdef LUT_SCAN_CHECKSUM_EN
         S_CHECK: if (hs) state_d = S_FINISH;
`endif
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // abort wins over everything, including a handshake in the same cycle.
      if (abort) begin
         state_d = S_IDLE;
         pack_d  = '0;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         idx_q   <= '0;
         pack_q  <= '0;
`ifdef LUT_SCAN_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
`ifdef LUT_SCAN_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_lut_table_scanner.sv
// Directed bench for lut_table_scanner: 8-bit neuron ~addr[4] plus a 4-bit constant-1 neuron.
module tb_lut_table_scanner;

   logic        clk;
   logic        rst;
   logic        start, abort, m_ready;
   logic [7:0]  lut_addr;
   logic [0:0]  lut_data;
   logic [31:0] m_data;
   logic        m_valid, m_last, busy, done;
   logic [2:0]  dbg_state;

   logic        s_start, s_ready;
   logic [3:0]  s_addr;
   logic [0:0]  s_lut;
   logic [31:0] s_data;
   logic        s_valid, s_last, s_busy, s_done;
   logic [2:0]  s_dbg;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int done_cnt = 0;
   int widx = 0;
   int dc;
   int cyc;
   logic [31:0] exp_q[$];

`ifdef LUT_SCAN_CHECKSUM_EN
   localparam int NW = 9;
`else
   localparam int NW = 8;
`endif

   assign lut_data = ~lut_addr[4];
   assign s_lut    = 1'b1;

   lut_table_scanner #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .lut_addr(lut_addr), .lut_data(lut_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .dbg_state_o(dbg_state)
   );

   lut_table_scanner #(.IN_BITS(4), .OUT_BITS(1), .WORD_W(32)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .abort(1'b0),
      .lut_addr(s_addr), .lut_data(s_lut),
      .m_data(s_data), .m_valid(s_valid), .m_ready(s_ready), .m_last(s_last),
      .busy(s_busy), .done(s_done), .dbg_state_o(s_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic load_exp();
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h0000_FFFF);
`ifdef LUT_SCAN_CHECKSUM_EN
      exp_q.push_back(32'h0007_FFF8);
`endif
      widx = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: ready always; mode 1: ready 1-in-3 plus start spam
   task automatic collect(input int n, input int mode);
      int got = 0;
      int c = 0;
      bit stalled = 1'b0;
      logic [31:0] hold_d;
      logic [7:0]  hold_a;
      logic [31:0] exp;
      while (got < n && c < 3000) begin
         m_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
         if (mode == 1) start = (c % 5 == 2);
         if (stalled) begin
            check("stall_valid", {31'b0, m_valid}, 32'd1);
            check("stall_data", m_data, hold_d);
            check("stall_addr", {24'b0, lut_addr}, {24'b0, hold_a});
         end
         if (m_valid && m_ready) begin
            exp = exp_q.pop_front();
            check("word_data", m_data, exp);
            check("word_last", {31'b0, m_last}, {31'b0, (widx == NW - 1)});
            widx++;
            got++;
            stalled = 1'b0;
         end else if (m_valid) begin
            stalled = 1'b1;
            hold_d  = m_data;
            hold_a  = lut_addr;
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      m_ready = 1'b0;
      start   = 1'b0;
      check("collect_count", got, n);
   endtask

   task automatic finish_checks();
      check("done_pulse", {31'b0, done}, 32'd1);
      check("busy_in_finish", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("done_clear", {31'b0, done}, 32'd0);
      check("busy_clear", {31'b0, busy}, 32'd0);
      check("addr_hold", {24'b0, lut_addr}, 32'h0000_00FF);
      check("done_count", done_cnt, dc + 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
      s_start = 1'b0; s_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_addr", {24'b0, lut_addr}, 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      check("rst_last", {31'b0, m_last}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Scan 1: timing of first word, m_ready=1
      load_exp();
      dc = done_cnt;
      pulse_start();
      check("t1_busy", {31'b0, busy}, 32'd1);
      check("t1_addr0", {24'b0, lut_addr}, 32'd0);
      repeat (63) @(negedge clk);
      check("t1_valid_early", {31'b0, m_valid}, 32'd0);
      @(negedge clk);
      check("t1_valid_rise", {31'b0, m_valid}, 32'd1);
      check("t1_addr31", {24'b0, lut_addr}, 32'd31);
      collect(NW, 0);
      finish_checks();

      // Scan 2: m_ready 1-in-3 with start pulsed mid-scan
      load_exp();
      dc = done_cnt;
      pulse_start();
      collect(NW, 1);
      finish_checks();

      // Small neuron: IN_BITS=4, constant 1
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (31) @(negedge clk);
      check("s_valid_early", {31'b0, s_valid}, 32'd0);
      @(negedge clk);
      check("s_valid", {31'b0, s_valid}, 32'd1);
      check("s_data", s_data, 32'h0000_FFFF);
`ifdef LUT_SCAN_CHECKSUM_EN
      check("s_last_table", {31'b0, s_last}, 32'd0);
      s_ready = 1'b1;
      @(negedge clk);
      check("s_csum_data", s_data, 32'h0000_FFFF);
      check("s_csum_last", {31'b0, s_last}, 32'd1);
`else
      check("s_last", {31'b0, s_last}, 32'd1);
      s_ready = 1'b1;
`endif
      @(negedge clk);
      s_ready = 1'b0;
      check("s_done", {31'b0, s_done}, 32'd1);
      @(negedge clk);
      check("s_busy_clear", {31'b0, s_busy}, 32'd0);

      // Abort during third EMIT with m_ready=1
      load_exp();
      pulse_start();
      collect(2, 0);
      cyc = 0;
      while (!m_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_reach_emit", {31'b0, m_valid}, 32'd1);
      dc = done_cnt;
      m_ready = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      m_ready = 1'b0;
      check("abort_valid", {31'b0, m_valid}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_last", {31'b0, m_last}, 32'd0);
      check("abort_data", m_data, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_no_done", done_cnt, dc);

      // Restart after abort
      load_exp();
      dc = done_cnt;
      pulse_start();
      check("restart_addr0", {24'b0, lut_addr}, 32'd0);
      collect(NW, 0);
      finish_checks();

      // Asynchronous reset mid-scan
      pulse_start();
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_addr", {24'b0, lut_addr}, 32'd0);
      check("arst_data", m_data, 32'd0);
      check("arst_valid", {31'b0, m_valid}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("arst_idle", {31'b0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
